// File: rtl/audio_event_sequencer.sv
// audio_event_sequencer: turns game-event pulses into timed, mutually exclusive audio requests with a per-source queue
module audio_event_sequencer #(
    parameter int TICK_DIV     = 25000,
    parameter int KEY_TICKS    = 100,
    parameter int HOLE_TICKS   = 400,
    parameter int BORDER_TICKS = 150,
    parameter int GAP_TICKS    = 20
) (
    input  logic clk,
    input  logic resetN,
    input  logic keyEvent,
    input  logic holeColEvent,
    input  logic borderColEvent,
    input  logic mute,
    output logic keyAudioRequest,
    output logic holeColAudioRequest,
    output logic borderColAudioRequest,
    output logic enableSound,
    output logic busy
);
    localparam int MAX_A = KEY_TICKS > HOLE_TICKS ? KEY_TICKS : HOLE_TICKS;
    localparam int MAX_B = BORDER_TICKS > GAP_TICKS ? BORDER_TICKS : GAP_TICKS;
    localparam int MAX_T = MAX_A > MAX_B ? MAX_A : MAX_B;
    localparam int DW = $clog2(TICK_DIV);
    localparam int TW = $clog2(MAX_T + 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    // one-hot source vectors use bit 2 = hole, bit 1 = border, bit 0 = key
    state_t state;
    logic [2:0] in_now, prev, ev, req, pend, pend_ev, pick_ev, pick_pn;
    logic [DW-1:0] div;
    logic [TW-1:0] tcnt, tlast;
    logic tick, done, again;
    int lim;

    function automatic logic [2:0] pick(input logic [2:0] v);
        return v[2] ? 3'b100 : v[1] ? 3'b010 : v[0] ? 3'b001 : 3'b000;
    endfunction

    assign in_now = {holeColEvent, borderColEvent, keyEvent};
    assign holeColAudioRequest   = req[2];
    assign borderColAudioRequest = req[1];
    assign keyAudioRequest       = req[0];
    assign enableSound           = |req;

    // edge detection, priority selection and duration limit of the current phase
    always_comb begin
        ev      = in_now & ~prev;
        pend_ev = pend | ev;
        pick_ev = pick(ev);
        pick_pn = pick(pend_ev);
        lim     = state == GAP ? GAP_TICKS : req[2] ? HOLE_TICKS : req[1] ? BORDER_TICKS : KEY_TICKS;
        tlast   = TW'(lim - 1);
        tick    = div == DW'(TICK_DIV - 1);
        done    = tick && tcnt == tlast;
        again   = |(ev & req);
    end

    // sequencer: edge registers, play/gap timing, pending queue and registered outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
            prev  <= 3'b111;
            req   <= 3'b000;
            pend  <= 3'b000;
            div   <= '0;
            tcnt  <= '0;
            busy  <= 1'b0;
        end else begin
            prev <= in_now;
            if (mute) begin
                state <= IDLE;
                req   <= 3'b000;
                pend  <= 3'b000;
                div   <= '0;
                tcnt  <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (|ev) begin
                            state <= PLAY;
                            req   <= pick_ev;
                            pend  <= ev & ~pick_ev;
                            div   <= '0;
                            tcnt  <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    PLAY: begin
                        pend <= pend | (ev & ~req);
                        if (again) begin
                            div  <= '0;
                            tcnt <= '0;
                        end else if (done) begin
                            state <= GAP;
                            req   <= 3'b000;
                            div   <= '0;
                            tcnt  <= '0;
                        end else begin
                            div <= tick ? '0 : div + 1'b1;
                            if (tick) tcnt <= tcnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (done) begin
                            if (|pend_ev) begin
                                state <= PLAY;
                                req   <= pick_pn;
                                pend  <= pend_ev & ~pick_pn;
                            end else begin
                                state <= IDLE;
                                pend  <= 3'b000;
                                busy  <= 1'b0;
                            end
                            div  <= '0;
                            tcnt <= '0;
                        end else begin
                            pend <= pend_ev;
                            div  <= tick ? '0 : div + 1'b1;
                            if (tick) tcnt <= tcnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_audio_event_sequencer.sv
// tb_audio_event_sequencer: directed scenarios with hand-computed per-cycle expectations
module tb_audio_event_sequencer;
    logic clk = 1'b0;
    logic resetN, keyEvent, holeColEvent, borderColEvent, mute;
    logic keyAudioRequest, holeColAudioRequest, borderColAudioRequest, enableSound, busy;
    int vectors = 0;
    int miscompares = 0;

    audio_event_sequencer #(
        .TICK_DIV(4), .KEY_TICKS(3), .HOLE_TICKS(5), .BORDER_TICKS(2), .GAP_TICKS(1)
    ) dut (
        .clk(clk), .resetN(resetN), .keyEvent(keyEvent), .holeColEvent(holeColEvent),
        .borderColEvent(borderColEvent), .mute(mute), .keyAudioRequest(keyAudioRequest),
        .holeColAudioRequest(holeColAudioRequest), .borderColAudioRequest(borderColAudioRequest),
        .enableSound(enableSound), .busy(busy)
    );

    always #5 clk = ~clk;

    // leaves the bench just after a rising edge at the start of cycle 0, inputs low
    task automatic do_reset();
        resetN = 1'b0; keyEvent = 1'b0; holeColEvent = 1'b0; borderColEvent = 1'b0; mute = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
    endtask

    task automatic test_reset();
        resetN = 1'b0; keyEvent = 1'b1; holeColEvent = 1'b0; borderColEvent = 1'b0; mute = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({holeColAudioRequest, borderColAudioRequest, keyAudioRequest, enableSound, busy} !== 5'b00000) begin
                miscompares++;
                $display("FAIL reset_hold c=%0d got %b exp 00000", c,
                         {holeColAudioRequest, borderColAudioRequest, keyAudioRequest, enableSound, busy});
            end
        end
        @(posedge clk);
        #1 resetN = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            vectors++;
            if ({holeColAudioRequest, borderColAudioRequest, keyAudioRequest, enableSound, busy} !== 5'b00000) begin
                miscompares++;
                $display("FAIL reset_release c=%0d got %b exp 00000", c,
                         {holeColAudioRequest, borderColAudioRequest, keyAudioRequest, enableSound, busy});
            end
            @(posedge clk);
            #1;
        end
        keyEvent = 1'b0;
    endtask

    // key held high 10..40: one 12-cycle sound only
    task automatic test_single_key();
        logic k, bz;
        do_reset();
        for (int c = 0; c <= 45; c++) begin
            keyEvent = (c >= 10 && c <= 40);
            @(negedge clk);
            k = (c >= 11 && c <= 22);
            bz = (c >= 11 && c <= 26);
            vectors++;
            if ({holeColAudioRequest, borderColAudioRequest, keyAudioRequest, enableSound, busy} !== {2'b00, k, k, bz}) begin
                miscompares++;
                $display("FAIL single_key c=%0d got %b exp %b", c,
                         {holeColAudioRequest, borderColAudioRequest, keyAudioRequest, enableSound, busy}, {2'b00, k, k, bz});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_simultaneous();
        logic h, b, k, bz;
        do_reset();
        for (int c = 0; c <= 66; c++) begin
            keyEvent = (c == 10); holeColEvent = (c == 10); borderColEvent = (c == 10);
            @(negedge clk);
            h = (c >= 11 && c <= 30);
            b = (c >= 35 && c <= 42);
            k = (c >= 47 && c <= 58);
            bz = (c >= 11 && c <= 62);
            vectors++;
            if ({holeColAudioRequest, borderColAudioRequest, keyAudioRequest, enableSound, busy} !== {h, b, k, h | b | k, bz}) begin
                miscompares++;
                $display("FAIL simultaneous c=%0d got %b exp %b", c,
                         {holeColAudioRequest, borderColAudioRequest, keyAudioRequest, enableSound, busy}, {h, b, k, h | b | k, bz});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_retrigger();
        logic k, bz;
        do_reset();
        for (int c = 0; c <= 45; c++) begin
            keyEvent = (c == 10 || c == 15);
            @(negedge clk);
            k = (c >= 11 && c <= 27);
            bz = (c >= 11 && c <= 31);
            vectors++;
            if ({holeColAudioRequest, borderColAudioRequest, keyAudioRequest, enableSound, busy} !== {2'b00, k, k, bz}) begin
                miscompares++;
                $display("FAIL retrigger c=%0d got %b exp %b", c,
                         {holeColAudioRequest, borderColAudioRequest, keyAudioRequest, enableSound, busy}, {2'b00, k, k, bz});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_gap_queue();
        logic b, k, bz;
        do_reset();
        for (int c = 0; c <= 45; c++) begin
            borderColEvent = (c == 10); keyEvent = (c == 20);
            @(negedge clk);
            b = (c >= 11 && c <= 18);
            k = (c >= 23 && c <= 34);
            bz = (c >= 11 && c <= 38);
            vectors++;
            if ({holeColAudioRequest, borderColAudioRequest, keyAudioRequest, enableSound, busy} !== {1'b0, b, k, b | k, bz}) begin
                miscompares++;
                $display("FAIL gap_queue c=%0d got %b exp %b", c,
                         {holeColAudioRequest, borderColAudioRequest, keyAudioRequest, enableSound, busy}, {1'b0, b, k, b | k, bz});
            end
            @(posedge clk);
            #1;
        end
    endtask

    // key lands on the last play cycle, hole on the last gap cycle: both kept, hole wins the next slot
    task automatic test_expiry_edge();
        logic h, b, k, bz;
        do_reset();
        for (int c = 0; c <= 66; c++) begin
            borderColEvent = (c == 10); keyEvent = (c == 18); holeColEvent = (c == 22);
            @(negedge clk);
            b = (c >= 11 && c <= 18);
            h = (c >= 23 && c <= 42);
            k = (c >= 47 && c <= 58);
            bz = (c >= 11 && c <= 62);
            vectors++;
            if ({holeColAudioRequest, borderColAudioRequest, keyAudioRequest, enableSound, busy} !== {h, b, k, h | b | k, bz}) begin
                miscompares++;
                $display("FAIL expiry_edge c=%0d got %b exp %b", c,
                         {holeColAudioRequest, borderColAudioRequest, keyAudioRequest, enableSound, busy}, {h, b, k, h | b | k, bz});
            end
            @(posedge clk);
            #1;
        end
    endtask

    // border held high across mute release must not fire; a fresh rise at 30 plays
    task automatic test_mute();
        logic h, b, bz;
        do_reset();
        for (int c = 0; c <= 48; c++) begin
            holeColEvent = (c == 10);
            mute = (c >= 14 && c <= 24);
            borderColEvent = (c >= 18 && c <= 27) || c >= 30;
            @(negedge clk);
            h = (c >= 11 && c <= 14);
            b = (c >= 31 && c <= 38);
            bz = (c >= 11 && c <= 14) || (c >= 31 && c <= 42);
            vectors++;
            if ({holeColAudioRequest, borderColAudioRequest, keyAudioRequest, enableSound, busy} !== {h, b, 1'b0, h | b, bz}) begin
                miscompares++;
                $display("FAIL mute c=%0d got %b exp %b", c,
                         {holeColAudioRequest, borderColAudioRequest, keyAudioRequest, enableSound, busy}, {h, b, 1'b0, h | b, bz});
            end
            @(posedge clk);
            #1;
        end
        mute = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_simultaneous();
        test_retrigger();
        test_gap_queue();
        test_expiry_edge();
        test_mute();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
